// File: rtl/lsb_evt.sv
// -----------------------------------------------------------------------------
// lsb_evt -- input-side companion of the LED/switch/button device.
//
// Synchronises and debounces the raw buttons and switches, latches press,
// release and switch-change events until software clears them, and raises a
// level interrupt while any enabled event is pending. The block sits at a
// single address on the internal bus and answers every access in one cycle.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous reset, active-low (synchronous release upstream)
//   stb        device select
//   we         write enable, qualified by stb
//   data_in    write data
//               [31]     0 = write-1-to-clear events, 1 = load enable mask
//               [21:12]  switch change events
//               [11:8]   button release events
//               [7:4]    button press events
//   data_out   read data while stb & ~we, otherwise 0
//               [31:22] switch level, [21:12] chg, [11:8] release,
//               [7:4] press, [3:0] button level
//   ack        bus acknowledge (= stb)
//   irq        registered interrupt, high while (pending & enable) != 0
//   btn_in_n   raw buttons, active-low, asynchronous to clk
//   swi_in     raw switches, asynchronous to clk
//   btn_out    debounced buttons, active-high
//   swi_out    debounced switches
//
// Parameter
//   DEB_CYCLES clock cycles per debounce sample tick, legal range 1..65535
// -----------------------------------------------------------------------------
module lsb_evt #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stb,
    input  logic        we,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    output logic        irq,
    input  logic [3:0]  btn_in_n,
    input  logic [9:0]  swi_in,
    output logic [3:0]  btn_out,
    output logic [9:0]  swi_out
);

    // Event vector laid out exactly like data_in/data_out bits [21:4], so the
    // clear and enable fields can be taken from the bus with a single slice.
    typedef struct packed {
        logic [9:0] chg;
        logic [3:0] rel;
        logic [3:0] press;
    } evt_t;

    localparam logic [15:0] DEB_LAST = DEB_CYCLES - 16'd1;

    // -------------------------------------------------------------------------
    // Two-flop synchronisers. Buttons stay active-low through the chain so the
    // reset value (all 1s) reads as "not pressed"; inversion happens after.
    // -------------------------------------------------------------------------
    logic [3:0] btn_meta_n;
    logic [3:0] btn_sync_n;
    logic [9:0] swi_meta;
    logic [9:0] swi_sync;
    logic [3:0] btn_sync;

    // NOTE: every clocked block uses non-blocking assignments so all flops
    // sample the pre-edge values of each other, as real hardware does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_n <= '1;
            btn_sync_n <= '1;
            swi_meta   <= '0;
            swi_sync   <= '0;
        end else begin
            btn_meta_n <= btn_in_n;
            btn_sync_n <= btn_meta_n;
            swi_meta   <= swi_in;
            swi_sync   <= swi_meta;
        end
    end

    assign btn_sync = ~btn_sync_n;

    // -------------------------------------------------------------------------
    // Prescaler: one-cycle tick every DEB_CYCLES clocks. With DEB_CYCLES = 1
    // the count is pinned at 0 and the tick is permanently high.
    // -------------------------------------------------------------------------
    logic [15:0] pre_cnt;
    logic        tick;

    assign tick = (pre_cnt == DEB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 16'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce. A bit flips its level only when the current synced value
    // matches the previous tick sample and differs from the level, i.e. two
    // consecutive equal samples. The update masks double as edge detectors.
    // -------------------------------------------------------------------------
    logic [3:0] btn_smp;
    logic [3:0] btn_lvl;
    logic [9:0] swi_smp;
    logic [9:0] swi_lvl;
    logic [3:0] btn_upd;
    logic [9:0] swi_upd;

    // NOTE: each always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        btn_upd = '0;
        swi_upd = '0;
        if (tick) begin
            btn_upd = ~(btn_sync ^ btn_smp) & (btn_sync ^ btn_lvl);
            swi_upd = ~(swi_sync ^ swi_smp) & (swi_sync ^ swi_lvl);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_smp <= '0;
            btn_lvl <= '0;
            swi_smp <= '0;
            swi_lvl <= '0;
        end else begin
            if (tick) begin
                btn_smp <= btn_sync;
                swi_smp <= swi_sync;
            end
            btn_lvl <= btn_lvl ^ btn_upd;
            swi_lvl <= swi_lvl ^ swi_upd;
        end
    end

    assign btn_out = btn_lvl;
    assign swi_out = swi_lvl;

    // -------------------------------------------------------------------------
    // Bus decode.
    // -------------------------------------------------------------------------
    logic rd_en;
    logic wr_en;
    logic clr_wr;
    logic ena_wr;

    assign rd_en  = stb & ~we;
    assign wr_en  = stb & we;
    assign clr_wr = wr_en & ~data_in[31];
    assign ena_wr = wr_en & data_in[31];

    // Bits of data_in that carry no meaning for this device.
    logic unused_data_in;
    assign unused_data_in = ^{data_in[30:22], data_in[3:0]};

    // -------------------------------------------------------------------------
    // Event latches and enable mask. Sets are ORed in after the clear, so an
    // event arriving in the same cycle as its clear is never lost.
    // -------------------------------------------------------------------------
    evt_t pending;
    evt_t enable;
    evt_t evt_set;
    evt_t evt_clr;

    always_comb begin
        evt_set       = '0;
        evt_set.press = btn_upd & btn_sync;
        evt_set.rel   = btn_upd & ~btn_sync;
        evt_set.chg   = swi_upd;

        evt_clr = '0;
        if (clr_wr) begin
            evt_clr = evt_t'(data_in[21:4]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            enable  <= '0;
            irq     <= 1'b0;
        end else begin
            pending <= (pending & ~evt_clr) | evt_set;
            if (ena_wr) begin
                enable <= evt_t'(data_in[21:4]);
            end
            // Built from the registered latches and mask, so irq follows a
            // latch set or mask write by exactly one clock.
            irq <= |(pending & enable);
        end
    end

    // -------------------------------------------------------------------------
    // Read path: combinational, side-effect free, zero when not reading.
    // -------------------------------------------------------------------------
    assign data_out = rd_en ? {swi_lvl, pending, btn_lvl} : 32'h0;
    assign ack      = stb;

endmodule
